// File: rtl/glyph_row_fetcher.sv
// Walks one digit glyph ROM row by row over a shared address bus and
// presents each packed row on a valid/ready stream.
module glyph_row_fetcher #(
    parameter int unsigned GLYPH_W    = 8,
    parameter int unsigned GLYPH_H    = 16,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned NUM_GLYPHS = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [3:0]                 digit,
    output logic                       busy,
    output logic                       done,
    output logic                       start_err,
    output logic [ADDR_W-1:0]          rom_address,
    input  logic [NUM_GLYPHS-1:0]      rom_q,
    output logic                       row_valid,
    input  logic                       row_ready,
    output logic [GLYPH_W-1:0]         row_data,
    output logic [$clog2(GLYPH_H)-1:0] row_index,
    output logic                       row_last
);

    localparam int unsigned COL_W = $clog2(GLYPH_W);
    localparam int unsigned ROW_W = $clog2(GLYPH_H);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(GLYPH_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GLYPH_H - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [3:0]         digit_q;
    logic [3:0]         digit_n;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_n;
    logic [COL_W-1:0]   col_inc;
    logic [ROW_W-1:0]   row_inc;
    logic               issued;
    logic               issued_n;
    logic               cap_en;
    logic               digit_ok;
    logic               handshake;

    logic               busy_n;
    logic               done_n;
    logic               start_err_n;
    logic [ADDR_W-1:0]  addr_n;
    logic               valid_n;
    logic [GLYPH_W-1:0] data_n;
    logic [ROW_W-1:0]   index_n;
    logic               last_n;

    assign digit_ok  = 5'(digit) < 5'(NUM_GLYPHS);
    assign col_inc   = col + COL_W'(1);
    assign row_inc   = row_index + ROW_W'(1);
    assign handshake = row_valid && row_ready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && digit_ok) state_n = FETCH;
            FETCH:   if (col == COL_MAX) state_n = DRAIN;
            DRAIN:   state_n = PRESENT;
            PRESENT: if (handshake) state_n = row_last ? IDLE : FETCH;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        busy_n      = busy;
        done_n      = 1'b0;
        start_err_n = 1'b0;
        addr_n      = rom_address;
        valid_n     = row_valid;
        index_n     = row_index;
        last_n      = row_last;
        col_n       = col;
        digit_n     = digit_q;
        issued_n    = 1'b0;
        // q reflects the address issued two edges ago; cap_en tracks that
        data_n      = cap_en ? {row_data[GLYPH_W-2:0], rom_q[digit_q]} : row_data;
        case (state)
            IDLE: begin
                if (start && !digit_ok) begin
                    start_err_n = 1'b1;
                end else if (start) begin
                    digit_n  = digit;
                    index_n  = '0;
                    col_n    = '0;
                    addr_n   = '0;
                    issued_n = 1'b1;
                    busy_n   = 1'b1;
                end
            end
            FETCH: begin
                if (col == COL_MAX) begin
                    col_n = '0;
                end else begin
                    col_n    = col_inc;
                    addr_n   = ADDR_W'({row_index, col_inc});
                    issued_n = 1'b1;
                end
            end
            DRAIN: begin
                valid_n = 1'b1;
                last_n  = (row_index == ROW_MAX);
            end
            PRESENT: begin
                if (handshake) begin
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                    if (row_last) begin
                        busy_n = 1'b0;
                        done_n = 1'b1;
                        addr_n = '0;
                    end else begin
                        index_n  = row_inc;
                        col_n    = '0;
                        addr_n   = ADDR_W'({row_inc, COL_W'(0)});
                        issued_n = 1'b1;
                    end
                end
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            start_err   <= 1'b0;
            rom_address <= '0;
            row_valid   <= 1'b0;
            row_data    <= '0;
            row_index   <= '0;
            row_last    <= 1'b0;
            col         <= '0;
            digit_q     <= '0;
            issued      <= 1'b0;
            cap_en      <= 1'b0;
        end else begin
            busy        <= busy_n;
            done        <= done_n;
            start_err   <= start_err_n;
            rom_address <= addr_n;
            row_valid   <= valid_n;
            row_data    <= data_n;
            row_index   <= index_n;
            row_last    <= last_n;
            col         <= col_n;
            digit_q     <= digit_n;
            issued      <= issued_n;
            cap_en      <= issued;
        end
    end

endmodule
